cv32e40p_alu_vote_dispatch_ft: RTL
==================================

CV32E40P_ALU_VOTE_DISPATCH_FT -- requirements
Module: cv32e40p_alu_vote_dispatch_ft

Interface
REQ-001 SHALL have parameter ALU_OP_WIDTH, default 7, meaning operator width from cv32e40p_pkg.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning ALU result width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  ALU operation issued this cycle.
- alu_operator_i  in  ALU_OP_WIDTH  operator of issued op.
- alu_result_i  in  [3:0][DATA_WIDTH]  combinational results of the 4 ALUs, same cycle.
- permanent_faulty_alu_i  in  [3:0][8:0]  sticky fault map (ALU x class) from the error counter.
- ready_o  out  1  op may be issued.
- alu_enable_o  out  [3:0]  ALUs executing this cycle.
- result_o  out  DATA_WIDTH  voted result.
- result_valid_o  out  1  result_o valid.
- error_detected_o  out  [3:0]  per-ALU mismatch, counter input.
- no_majority_o  out  1  vote failed.
- clock_en_o  out  [3:0]  counter clock enables.

Function
REQ-005 Operator class SHALL be: 0 add/sub/shift/rotate, 1 xor/or/and, 2 bext/bextu/bins/bclr/bset/brev, 3 ff1/fl1/cnt/clb, 4 exts/ext/shuf/shuf2/pcklo/pckhi/ins, 5 all compare/slt/slet, 6 abs/clip/clipu, 7 min/max(u), 8 div/divu/rem/remu; any other operator = unclassified.
REQ-006 Block SHALL hold a 9-entry selection table (4-bit mask per class) and a registered 36-bit fault-map snapshot.
REQ-007 Mask for class c SHALL be the three lowest-index ALUs with faulty[k][c]=0 if >=3 healthy; both if 2; the one if 1; 4'b0001 if 0.
REQ-008 FSM states SHALL be IDLE and UPDATE; IDLE->UPDATE when permanent_faulty_alu_i != snapshot, capturing snapshot and setting class index to 0.
REQ-009 UPDATE SHALL recompute one table entry per cycle (index 0..8) from the snapshot; UPDATE->IDLE after entry 8 (9 cycles).
REQ-010 If input differs from snapshot during UPDATE, next cycle SHALL recapture snapshot and restart at index 0.
REQ-011 ready_o SHALL be 1 in IDLE only.
REQ-012 alu_enable_o SHALL equal table[class] when valid_i && ready_o, unclassified using 4'b0111; else 4'b0000 (combinational).
REQ-013 valid_i while ready_o=0 SHALL be ignored; no result, no error pulse.
REQ-014 Vote SHALL use enabled ALUs: majority value = any value shared by >=2 enabled ALUs; single enabled ALU = its value.
REQ-015 One cycle after issue: result_valid_o=1; result_o = majority value, else lowest-index enabled ALU result; error_detected_o[k]=1 iff ALU k enabled and result != majority value, all enabled ALUs flagged when no majority; no_majority_o=1 iff >=2 enabled and no majority.
REQ-016 Outputs SHALL be 0 in cycles following no accepted issue (single-cycle pulses).
REQ-017 clock_en_o[k] SHALL be 0 iff all 9 class bits of ALU k in snapshot are 1, else 1 (registered).
REQ-018 Issue and table update SHALL never coincide (ready_o=0 in UPDATE); pipeline output from an issue accepted in the IDLE->UPDATE transition cycle SHALL still be produced.

Reset
REQ-019 On rst: FSM IDLE, index 0, snapshot all 0, every table entry 4'b0111, result_o 0, result_valid_o 0, error_detected_o 0, no_majority_o 0, clock_en_o 4'b1111; ready_o 1 after reset.
REQ-020 rst mid-UPDATE SHALL abort update and restore reset state; an in-flight result SHALL be dropped.

Verification
REQ-021 Reset, issue ALU_ADD, results {x,5,5,5} (ALU0..2 =5) -> next cycle result_o=5, result_valid_o=1, error_detected_o=0, alu_enable_o was 4'b0111.
REQ-022 Issue ALU_XOR, ALU1 returns 9, others 3 -> result_o=3, error_detected_o=4'b0010, no_majority_o=0.
REQ-023 Set faulty[1][0]=1 -> ready_o low exactly 9 cycles; then ALU_ADD enables 4'b1101, ALU_XOR still 4'b0111.
REQ-024 Set faulty[0][5] and faulty[1][5] -> compare enables 4'b1100; results 1 vs 0 -> result_o=ALU2 value, error_detected_o=4'b1100, no_majority_o=1.
REQ-025 Fault map change at UPDATE index 4 -> restart; ready_o low 5+9 cycles total; issue with ready_o=0 produces no output.
REQ-026 All 9 bits of ALU3 set -> clock_en_o=4'b0111; rst asserted mid-UPDATE -> all reset values next cycle.

Source files
------------

// File: rtl/cv32e40p_alu_vote_dispatch_ft.sv
// Fault-tolerant ALU dispatcher and voter.
// Picks which of four redundant ALUs execute each operation, based on a
// per-class table rebuilt from a sticky permanent-fault map, and votes on
// their results one cycle later.
//
// Handshake: an operation is accepted in a cycle where valid_i && ready_o;
// ready_o is low while the selection table is being rebuilt, and valid_i in
// such a cycle is dropped (no result, no error pulse). Accepted operations
// produce exactly one result_valid_o pulse on the following cycle.
module cv32e40p_alu_vote_dispatch_ft #(
   parameter int ALU_OP_WIDTH = 7,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         valid_i,
   input  logic [ALU_OP_WIDTH-1:0]      alu_operator_i,
   input  logic [3:0][DATA_WIDTH-1:0]   alu_result_i,
   input  logic [3:0][8:0]              permanent_faulty_alu_i,
   output logic                         ready_o,
   output logic [3:0]                   alu_enable_o,
   output logic [DATA_WIDTH-1:0]        result_o,
   output logic                         result_valid_o,
   output logic [3:0]                   error_detected_o,
   output logic                         no_majority_o,
   output logic [3:0]                   clock_en_o
);

   typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_e;

   localparam logic [3:0] CLS_NONE = 4'd9;

   state_e                  state_q;
   logic [3:0]              idx_q;
   logic [3:0][8:0]         snap_q, snap_d;
   logic [3:0]              table_q [9];
   logic [3:0]              clock_en_q;
   logic                    fault_change;

   logic [3:0]              op_cls;
   logic                    issue;

   logic [2:0]              n_en;
   logic                    first_found, maj_found;
   logic [DATA_WIDTH-1:0]   first_val, maj_val;
   logic [DATA_WIDTH-1:0]   vote_result;
   logic [3:0]              vote_err;
   logic                    vote_nomaj;

   logic [DATA_WIDTH-1:0]   result_q;
   logic                    result_valid_q;
   logic [3:0]              err_q;
   logic                    nomaj_q;

   // Map an operator to its fault class; 9 means unclassified.
   function automatic logic [3:0] op_class(input logic [ALU_OP_WIDTH-1:0] op);
      case (op)
         7'b0011000, 7'b0011001, 7'b0011010, 7'b0011011,
         7'b0011100, 7'b0011101, 7'b0011110, 7'b0011111,
         7'b0100100, 7'b0100101, 7'b0100110, 7'b0100111: return 4'd0;
         7'b0101111, 7'b0101110, 7'b0010101:             return 4'd1;
         7'b0101000, 7'b0101001, 7'b0101010, 7'b0101011,
         7'b0101100, 7'b1001001:                         return 4'd2;
         7'b0110110, 7'b0110111, 7'b0110100, 7'b0110101: return 4'd3;
         7'b0111110, 7'b0111111, 7'b0111010, 7'b0111011,
         7'b0111000, 7'b0111001, 7'b0101101:             return 4'd4;
         7'b0000000, 7'b0000001, 7'b0000100, 7'b0000101,
         7'b0001000, 7'b0001001, 7'b0001010, 7'b0001011,
         7'b0001100, 7'b0001101, 7'b0000010, 7'b0000011,
         7'b0000110, 7'b0000111:                         return 4'd5;
         7'b0010100, 7'b0010110, 7'b0010111:             return 4'd6;
         7'b0010000, 7'b0010001, 7'b0010010, 7'b0010011: return 4'd7;
         7'b0110000, 7'b0110001, 7'b0110010, 7'b0110011: return 4'd8;
         default:                                        return CLS_NONE;
      endcase
   endfunction

   // Up to three lowest-index healthy ALUs for a class; ALU0 alone if none.
   function automatic logic [3:0] class_mask(input logic [3:0][8:0] f, input logic [3:0] c);
      logic [3:0] m;
      logic [1:0] n;
      m = 4'b0000;
      n = 2'd0;
      for (int k = 0; k < 4; k++) begin
         if (!f[k][c] && (n < 2'd3)) begin
            m[k] = 1'b1;
            n    = n + 2'd1;
         end
      end
      if (m == 4'b0000) m = 4'b0001;
      return m;
   endfunction

   // Snapshot follows the fault map whenever it changes, in either state.
   always_comb begin
      fault_change = (permanent_faulty_alu_i != snap_q);
      snap_d       = fault_change ? permanent_faulty_alu_i : snap_q;
   end

   // Dispatch: classify the operator and enable the selected ALUs on accept.
   always_comb begin
      ready_o      = (state_q == IDLE);
      issue        = valid_i && ready_o;
      op_cls       = op_class(alu_operator_i);
      alu_enable_o = 4'b0000;
      if (issue) alu_enable_o = (op_cls == CLS_NONE) ? 4'b0111 : table_q[op_cls];
   end

   // Vote over the enabled ALUs: first equal pair wins, single ALU wins alone.
   always_comb begin
      n_en        = 3'd0;
      first_found = 1'b0;
      first_val   = '0;
      maj_found   = 1'b0;
      maj_val     = '0;
      vote_err    = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         if (alu_enable_o[i]) begin
            n_en = n_en + 3'd1;
            if (!first_found) begin
               first_found = 1'b1;
               first_val   = alu_result_i[i];
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = i + 1; j < 4; j++) begin
            if (!maj_found && alu_enable_o[i] && alu_enable_o[j] &&
                (alu_result_i[i] == alu_result_i[j])) begin
               maj_found = 1'b1;
               maj_val   = alu_result_i[i];
            end
         end
      end
      if (n_en == 3'd1) begin
         maj_found = 1'b1;
         maj_val   = first_val;
      end
      vote_result = maj_found ? maj_val : first_val;
      for (int k = 0; k < 4; k++) begin
         vote_err[k] = alu_enable_o[k] && (!maj_found || (alu_result_i[k] != maj_val));
      end
      vote_nomaj = (n_en >= 3'd2) && !maj_found;
   end

   // Table-rebuild FSM: one class entry per cycle, restart on any map change.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= 4'd0;
         snap_q     <= '0;
         clock_en_q <= 4'b1111;
         for (int i = 0; i < 9; i++) table_q[i] <= 4'b0111;
      end else begin
         snap_q <= snap_d;
         for (int k = 0; k < 4; k++) clock_en_q[k] <= ~(&snap_d[k]);
         case (state_q)
            IDLE: begin
               if (fault_change) begin
                  idx_q   <= 4'd0;
                  state_q <= UPDATE;
               end
            end
            UPDATE: begin
               if (fault_change) begin
                  idx_q <= 4'd0;
               end else begin
                  table_q[idx_q] <= class_mask(snap_q, idx_q);
                  if (idx_q == 4'd8) begin
                     idx_q   <= 4'd0;
                     state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Result stage: single-cycle pulse for each accepted operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 4'b0000;
         nomaj_q        <= 1'b0;
      end else begin
         result_valid_q <= issue;
         result_q       <= issue ? vote_result : '0;
         err_q          <= issue ? vote_err : 4'b0000;
         nomaj_q        <= issue && vote_nomaj;
      end
   end

   assign result_o         = result_q;
   assign result_valid_o   = result_valid_q;
   assign error_detected_o = err_q;
   assign no_majority_o    = nomaj_q;
   assign clock_en_o       = clock_en_q;

endmodule
